// File: rtl/w0rm_alu_pkg.sv
// Shared definitions for the w0rm ALU issue controller: opcodes, unit indices,
// flag bit positions and controller state encoding.
package w0rm_alu_pkg;

    localparam int unsigned NUM_UNITS  = 5;
    localparam int unsigned UNIT_IDX_W = 3;
    localparam int unsigned NUM_FLAGS  = 4;

    localparam int unsigned UNIT_LOGIC  = 0;
    localparam int unsigned UNIT_MUL    = 1;
    localparam int unsigned UNIT_DIVREM = 2;
    localparam int unsigned UNIT_ADDSUB = 3;
    localparam int unsigned UNIT_SHIFTS = 4;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_C = 3;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_PASS = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_DIV  = 4'h6;
    localparam logic [3:0] OP_REM  = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_SLL  = 4'hC;
    localparam logic [3:0] OP_SRL  = 4'hD;
    localparam logic [3:0] OP_SRA  = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [UNIT_IDX_W-1:0] onehot_to_idx(input logic [NUM_UNITS-1:0] oh);
        logic [UNIT_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (oh[i]) idx = UNIT_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/w0rm_alu_opcode_decode.sv
// Combinational opcode decode: selects the functional unit (one-hot) or flags
// the opcode as illegal.
module w0rm_alu_opcode_decode
    import w0rm_alu_pkg::*;
(
    input  logic [3:0]           opcode_i,
    output logic [NUM_UNITS-1:0] unit_onehot_o,
    output logic                 illegal_o
);

    always_comb begin
        unit_onehot_o = '0;
        illegal_o     = 1'b0;
        case (opcode_i)
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_PASS: unit_onehot_o[UNIT_LOGIC]  = 1'b1;
            OP_MUL:                                 unit_onehot_o[UNIT_MUL]    = 1'b1;
            OP_DIV, OP_REM:                         unit_onehot_o[UNIT_DIVREM] = 1'b1;
            OP_ADD, OP_SUB:                         unit_onehot_o[UNIT_ADDSUB] = 1'b1;
            OP_SLL, OP_SRL, OP_SRA:                 unit_onehot_o[UNIT_SHIFTS] = 1'b1;
            default:                                illegal_o                  = 1'b1;
        endcase
    end

endmodule

// File: rtl/w0rm_alu_issue_ctrl.sv
// Issue sequencer for the five ALU functional units: one op in flight, unit
// enable pulse, watchdog-bounded wait, masked flag commit, valid/ready response.
module w0rm_alu_issue_ctrl
    import w0rm_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [3:0]                      req_opcode,
    input  logic [DATA_WIDTH-1:0]           req_data_a,
    input  logic [DATA_WIDTH-1:0]           req_data_b,
    input  logic [NUM_FLAGS-1:0]            req_flags_mask,
    output logic [NUM_UNITS-1:0]            unit_ce,
    output logic [3:0]                      unit_opcode,
    output logic [DATA_WIDTH-1:0]           unit_data_a,
    output logic [DATA_WIDTH-1:0]           unit_data_b,
    input  logic [NUM_UNITS-1:0]            unit_result_valid,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
    input  logic [NUM_UNITS*NUM_FLAGS-1:0]  unit_flags,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_result,
    output logic                            rsp_illegal,
    output logic                            rsp_timeout,
    output logic                            flag_zero,
    output logic                            flag_negative,
    output logic                            flag_overflow,
    output logic                            flag_carry
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_UNITS-1:0] dec_onehot;
    logic                 dec_illegal;

    w0rm_alu_opcode_decode u_decode (
        .opcode_i      (req_opcode),
        .unit_onehot_o (dec_onehot),
        .illegal_o     (dec_illegal)
    );

    state_e                  state_q;
    logic                    req_ready_q;
    logic [NUM_UNITS-1:0]    unit_ce_q;
    logic [3:0]              unit_opcode_q;
    logic [DATA_WIDTH-1:0]   unit_data_a_q;
    logic [DATA_WIDTH-1:0]   unit_data_b_q;
    logic [UNIT_IDX_W-1:0]   sel_idx_q;
    logic [NUM_FLAGS-1:0]    mask_q;
    logic [WD_W-1:0]         wdog_q;
    logic                    pend_q;
    logic [DATA_WIDTH-1:0]   pend_result_q;
    logic [NUM_FLAGS-1:0]    pend_flags_q;
    logic [NUM_FLAGS-1:0]    flags_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_result_q;
    logic                    rsp_illegal_q;
    logic                    rsp_timeout_q;

    logic                    sel_valid;
    logic [DATA_WIDTH-1:0]   sel_result;
    logic [NUM_FLAGS-1:0]    sel_flags;
    logic [DATA_WIDTH-1:0]   commit_result;
    logic [NUM_FLAGS-1:0]    commit_flags;
    logic [NUM_FLAGS-1:0]    flags_d;

    always_comb begin
        sel_valid  = 1'b0;
        sel_result = '0;
        sel_flags  = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (sel_idx_q == UNIT_IDX_W'(i)) begin
                sel_valid  = unit_result_valid[i];
                sel_result = unit_result[i*DATA_WIDTH +: DATA_WIDTH];
                sel_flags  = unit_flags[i*NUM_FLAGS +: NUM_FLAGS];
            end
        end
    end

    // A result that arrives during ISSUE is parked and committed on the first
    // WAIT cycle, so flags change and rsp_valid rises together.
    always_comb begin
        commit_result = pend_q ? pend_result_q : sel_result;
        commit_flags  = pend_q ? pend_flags_q  : sel_flags;
        flags_d       = (flags_q & ~mask_q) | (commit_flags & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            unit_ce_q     <= '0;
            unit_opcode_q <= '0;
            unit_data_a_q <= '0;
            unit_data_b_q <= '0;
            sel_idx_q     <= '0;
            mask_q        <= '0;
            wdog_q        <= '0;
            pend_q        <= 1'b0;
            pend_result_q <= '0;
            pend_flags_q  <= '0;
            flags_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unit_ce_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (req_ready_q && req_valid) begin
                        req_ready_q   <= 1'b0;
                        unit_opcode_q <= req_opcode;
                        unit_data_a_q <= req_data_a;
                        unit_data_b_q <= req_data_b;
                        mask_q        <= req_flags_mask;
                        sel_idx_q     <= onehot_to_idx(dec_onehot);
                        if (dec_illegal) begin
                            state_q       <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_illegal_q <= 1'b1;
                            rsp_result_q  <= '0;
                        end else begin
                            state_q   <= ST_ISSUE;
                            unit_ce_q <= dec_onehot;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    wdog_q  <= WD_W'(1);
                    if (sel_valid) begin
                        pend_q        <= 1'b1;
                        pend_result_q <= sel_result;
                        pend_flags_q  <= sel_flags;
                    end
                end
                ST_WAIT: begin
                    if (pend_q || sel_valid) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= commit_result;
                        flags_q      <= flags_d;
                        pend_q       <= 1'b0;
                        wdog_q       <= '0;
                    end else if (wdog_q == WD_W'(TIMEOUT_CYCLES)) begin
                        state_q       <= ST_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_result_q  <= '0;
                        wdog_q        <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q       <= ST_IDLE;
                        req_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b0;
                        rsp_result_q  <= '0;
                        rsp_illegal_q <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign unit_ce       = unit_ce_q;
    assign unit_opcode   = unit_opcode_q;
    assign unit_data_a   = unit_data_a_q;
    assign unit_data_b   = unit_data_b_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_illegal   = rsp_illegal_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign flag_zero     = flags_q[FLAG_Z];
    assign flag_negative = flags_q[FLAG_N];
    assign flag_overflow = flags_q[FLAG_V];
    assign flag_carry    = flags_q[FLAG_C];

endmodule
